// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 exception controller: register numbers,
// exception codes, Status/Cause field positions and the exception vector.
package cp0_pkg;

    localparam logic [4:0] CP0_REG_STATUS = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_REG_EPC    = 5'd14;
    localparam logic [4:0] CP0_REG_PRID   = 5'd15;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    localparam int STATUS_IE_BIT  = 0;
    localparam int STATUS_EXL_BIT = 1;
    localparam int STATUS_IM_LSB  = 10;
    localparam int CAUSE_EXC_LSB  = 2;
    localparam int CAUSE_IP_LSB   = 10;

    localparam logic [31:0] EXC_VECTOR = 32'h0000_0800;

endpackage

// File: rtl/cp0_irq_sync.sv
// Two-flop synchronizer for the asynchronous external interrupt levels.
// The second stage doubles as Cause.IP in the controller.
module cp0_irq_sync #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] async_i,
    output logic [W-1:0] sync_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Shift the raw levels through two stages to resolve metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception controller: Status/Cause/EPC/PRId, exception
// priority, ERET and MTC0/MFC0 servicing for the single-cycle core.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h0001_8000,
    parameter int          IRQ_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [31:0]      pc,
    input  logic             is_mtc0,
    input  logic             is_mfc0,
    input  logic             is_eret,
    input  logic [4:0]       cp0_addr,
    input  logic [31:0]      wdata,
    input  logic             exc_illegal,
    input  logic             exc_syscall,
    input  logic             exc_overflow,
    input  logic [IRQ_W-1:0] irq,
    output logic             has_exp,
    output logic             eret_taken,
    output logic [31:0]      cp0_target_addr,
    output logic [31:0]      rdata
);

    logic             ie_q, ie_d;
    logic             exl_q, exl_d;
    logic [IRQ_W-1:0] im_q, im_d;
    logic [4:0]       exccode_q, exccode_d;
    logic [31:0]      epc_q, epc_d;
    logic [IRQ_W-1:0] ip;

    logic        req_valid;
    logic        int_pend;
    logic        mtc0_we;
    logic [4:0]  exc_code;
    logic [31:0] status_rd;
    logic [31:0] cause_rd;

    cp0_irq_sync #(.W(IRQ_W)) u_irq_sync (
        .clk     (clk),
        .rst_n   (rst),
        .async_i (irq),
        .sync_o  (ip)
    );

    // Requests are also masked by reset so every output is quiet while rst is low.
    assign req_valid  = instr_valid & rst;
    assign int_pend   = (|(ip & im_q)) & ie_q & ~exl_q & req_valid;
    assign has_exp    = req_valid & (exc_illegal | exc_syscall | exc_overflow | int_pend);
    assign eret_taken = req_valid & is_eret & ~has_exp;
    assign mtc0_we    = req_valid & is_mtc0 & ~has_exp;
    assign cp0_target_addr = epc_q;

    // Fixed-priority source select: illegal > syscall > overflow > interrupt.
    always_comb begin
        exc_code = EXC_INT;
        if (exc_illegal)       exc_code = EXC_RI;
        else if (exc_syscall)  exc_code = EXC_SYS;
        else if (exc_overflow) exc_code = EXC_OV;
    end

    // Assemble register read views and the MFC0 mux (old values, no bypass).
    always_comb begin
        status_rd = '0;
        status_rd[STATUS_IE_BIT]                 = ie_q;
        status_rd[STATUS_EXL_BIT]                = exl_q;
        status_rd[STATUS_IM_LSB +: IRQ_W]        = im_q;
        cause_rd  = '0;
        cause_rd[CAUSE_EXC_LSB +: 5]             = exccode_q;
        cause_rd[CAUSE_IP_LSB +: IRQ_W]          = ip;
        rdata = '0;
        if (req_valid && is_mfc0) begin
            case (cp0_addr)
                CP0_REG_STATUS: rdata = status_rd;
                CP0_REG_CAUSE:  rdata = cause_rd;
                CP0_REG_EPC:    rdata = epc_q;
                CP0_REG_PRID:   rdata = PRID_VALUE;
                default:        rdata = '0;
            endcase
        end
    end

    // Next-state: MTC0 first, then ERET, then exception entry overrides both.
    always_comb begin
        ie_d      = ie_q;
        exl_d     = exl_q;
        im_d      = im_q;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        if (mtc0_we) begin
            case (cp0_addr)
                CP0_REG_STATUS: begin
                    ie_d  = wdata[STATUS_IE_BIT];
                    exl_d = wdata[STATUS_EXL_BIT];
                    im_d  = wdata[STATUS_IM_LSB +: IRQ_W];
                end
                CP0_REG_CAUSE: exccode_d = wdata[CAUSE_EXC_LSB +: 5];
                CP0_REG_EPC:   epc_d     = wdata;
                default: ;
            endcase
        end
        if (eret_taken) exl_d = 1'b0;
        if (has_exp) begin
            exl_d     = 1'b1;
            exccode_d = exc_code;
            // A nested exception keeps the original return address.
            if (!exl_q) epc_d = pc;
        end
    end

    // CP0 register state; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ie_q      <= 1'b0;
            exl_q     <= 1'b0;
            im_q      <= '0;
            exccode_q <= '0;
            epc_q     <= '0;
        end else begin
            ie_q      <= ie_d;
            exl_q     <= exl_d;
            im_q      <= im_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: a sequential vector table plus
// hand-written interrupt-latency and asynchronous-reset sequences.
module tb_cp0_exc_ctrl;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [31:0] pc;
    logic        is_mtc0, is_mfc0, is_eret;
    logic [4:0]  cp0_addr;
    logic [31:0] wdata;
    logic        exc_illegal, exc_syscall, exc_overflow;
    logic [5:0]  irq;
    logic        has_exp, eret_taken;
    logic [31:0] cp0_target_addr, rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        mtc0, mfc0, eret;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        ill, sys, ov;
        logic        e_has, e_eret;
        logic [31:0] e_rd, e_tgt;
    } vec_t;

    vec_t vecs[$];

    cp0_exc_ctrl #(.PRID_VALUE(32'h0001_8000), .IRQ_W(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .instr_valid     (instr_valid),
        .pc              (pc),
        .is_mtc0         (is_mtc0),
        .is_mfc0         (is_mfc0),
        .is_eret         (is_eret),
        .cp0_addr        (cp0_addr),
        .wdata           (wdata),
        .exc_illegal     (exc_illegal),
        .exc_syscall     (exc_syscall),
        .exc_overflow    (exc_overflow),
        .irq             (irq),
        .has_exp         (has_exp),
        .eret_taken      (eret_taken),
        .cp0_target_addr (cp0_target_addr),
        .rdata           (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic v, logic [31:0] p, logic mt, logic mf, logic er,
                                logic [4:0] a, logic [31:0] wd, logic il, logic sy, logic o,
                                logic eh, logic ee, logic [31:0] erd, logic [31:0] et);
        vec_t x;
        x.v = v; x.pc = p; x.mtc0 = mt; x.mfc0 = mf; x.eret = er; x.addr = a;
        x.wdata = wd; x.ill = il; x.sys = sy; x.ov = o;
        x.e_has = eh; x.e_eret = ee; x.e_rd = erd; x.e_tgt = et;
        return x;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        instr_valid = 1'b1; pc = '0; is_mtc0 = 1'b0; is_mfc0 = 1'b0; is_eret = 1'b0;
        cp0_addr = '0; wdata = '0; exc_illegal = 1'b0; exc_syscall = 1'b0; exc_overflow = 1'b0;
    endtask

    task automatic drive(vec_t x);
        instr_valid = x.v; pc = x.pc; is_mtc0 = x.mtc0; is_mfc0 = x.mfc0; is_eret = x.eret;
        cp0_addr = x.addr; wdata = x.wdata;
        exc_illegal = x.ill; exc_syscall = x.sys; exc_overflow = x.ov;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // v  pc  mt mf er addr wdata  il sy ov | has eret rdata tgt
        vecs.push_back(mk(1, 32'h0,   0,1,0, 5'd12, 32'h0, 0,0,0, 0,0, 32'h0,       32'h0));
        vecs.push_back(mk(1, 32'h0,   0,1,0, 5'd13, 32'h0, 0,0,0, 0,0, 32'h0,       32'h0));
        vecs.push_back(mk(1, 32'h0,   0,1,0, 5'd14, 32'h0, 0,0,0, 0,0, 32'h0,       32'h0));
        vecs.push_back(mk(1, 32'h0,   0,1,0, 5'd15, 32'h0, 0,0,0, 0,0, 32'h0001_8000, 32'h0));
        vecs.push_back(mk(1, 32'h0,   0,1,0, 5'd20, 32'h0, 0,0,0, 0,0, 32'h0,       32'h0));
        vecs.push_back(mk(0, 32'h0,   0,1,0, 5'd15, 32'h0, 0,1,0, 0,0, 32'h0,       32'h0));
        vecs.push_back(mk(1, 32'h40,  0,0,0, 5'd0,  32'h0, 0,1,0, 1,0, 32'h0,       32'h0));
        vecs.push_back(mk(1, 32'h0,   0,1,0, 5'd14, 32'h0, 0,0,0, 0,0, 32'h40,      32'h40));
        vecs.push_back(mk(1, 32'h0,   0,1,0, 5'd12, 32'h0, 0,0,0, 0,0, 32'h2,       32'h40));
        vecs.push_back(mk(1, 32'h0,   0,1,0, 5'd13, 32'h0, 0,0,0, 0,0, 32'h20,      32'h40));
        vecs.push_back(mk(1, 32'h0,   0,0,1, 5'd0,  32'h0, 0,0,0, 0,1, 32'h0,       32'h40));
        vecs.push_back(mk(1, 32'h0,   0,1,0, 5'd12, 32'h0, 0,0,0, 0,0, 32'h0,       32'h40));
        vecs.push_back(mk(1, 32'h60,  0,0,0, 5'd0,  32'h0, 1,0,1, 1,0, 32'h0,       32'h40));
        vecs.push_back(mk(1, 32'h0,   0,1,0, 5'd13, 32'h0, 0,0,0, 0,0, 32'h28,      32'h60));
        vecs.push_back(mk(1, 32'h100, 0,0,0, 5'd0,  32'h0, 0,1,0, 1,0, 32'h0,       32'h60));
        vecs.push_back(mk(1, 32'h0,   0,1,0, 5'd13, 32'h0, 0,0,0, 0,0, 32'h20,      32'h60));
        vecs.push_back(mk(1, 32'h104, 0,0,1, 5'd0,  32'h0, 0,0,1, 1,0, 32'h0,       32'h60));
        vecs.push_back(mk(1, 32'h0,   0,1,0, 5'd12, 32'h0, 0,0,0, 0,0, 32'h2,       32'h60));
        vecs.push_back(mk(1, 32'h0,   0,1,0, 5'd13, 32'h0, 0,0,0, 0,0, 32'h30,      32'h60));
        vecs.push_back(mk(1, 32'h0,   0,1,0, 5'd14, 32'h0, 0,0,0, 0,0, 32'h60,      32'h60));
        vecs.push_back(mk(1, 32'h0,   0,0,1, 5'd0,  32'h0, 0,0,0, 0,1, 32'h0,       32'h60));
        vecs.push_back(mk(1, 32'h200, 1,0,0, 5'd14, 32'hDEAD_BEE0, 0,1,0, 1,0, 32'h0, 32'h60));
        vecs.push_back(mk(1, 32'h0,   0,1,0, 5'd14, 32'h0, 0,0,0, 0,0, 32'h200,     32'h200));
        vecs.push_back(mk(1, 32'h0,   0,0,1, 5'd0,  32'h0, 0,0,0, 0,1, 32'h0,       32'h200));
        vecs.push_back(mk(1, 32'h0,   1,1,0, 5'd14, 32'h1234_5678, 0,0,0, 0,0, 32'h200, 32'h200));
        vecs.push_back(mk(1, 32'h0,   0,1,0, 5'd14, 32'h0, 0,0,0, 0,0, 32'h1234_5678, 32'h1234_5678));
        vecs.push_back(mk(1, 32'h0,   1,0,0, 5'd12, 32'hFFFF_FFFF, 0,0,0, 0,0, 32'h0, 32'h1234_5678));
        vecs.push_back(mk(1, 32'h0,   0,1,0, 5'd12, 32'h0, 0,0,0, 0,0, 32'h0000_FC03, 32'h1234_5678));
        vecs.push_back(mk(1, 32'h0,   0,0,1, 5'd0,  32'h0, 0,0,0, 0,1, 32'h0,       32'h1234_5678));
        vecs.push_back(mk(1, 32'h0,   0,1,0, 5'd12, 32'h0, 0,0,0, 0,0, 32'h0000_FC01, 32'h1234_5678));
        vecs.push_back(mk(1, 32'h0,   0,0,1, 5'd0,  32'h0, 0,0,0, 0,1, 32'h0,       32'h1234_5678));
        vecs.push_back(mk(1, 32'h0,   1,0,0, 5'd12, 32'h0, 0,0,0, 0,0, 32'h0,       32'h1234_5678));
        vecs.push_back(mk(1, 32'h0,   0,1,0, 5'd12, 32'h0, 0,0,0, 0,0, 32'h0,       32'h1234_5678));
        vecs.push_back(mk(1, 32'h0,   1,0,0, 5'd20, 32'hFFFF_FFFF, 0,0,0, 0,0, 32'h0, 32'h1234_5678));
        vecs.push_back(mk(1, 32'h0,   0,1,0, 5'd12, 32'h0, 0,0,0, 0,0, 32'h0,       32'h1234_5678));
        vecs.push_back(mk(1, 32'h0,   0,1,0, 5'd13, 32'h0, 0,0,0, 0,0, 32'h20,      32'h1234_5678));

        // Reset: outputs quiet even with active requests.
        rst = 1'b0; irq = '0;
        idle();
        exc_syscall = 1'b1; is_mfc0 = 1'b1; is_eret = 1'b1; cp0_addr = 5'd15;
        #12;
        chk("rst has_exp",    {31'b0, has_exp},    32'h0);
        chk("rst eret_taken", {31'b0, eret_taken}, 32'h0);
        chk("rst rdata",      rdata,               32'h0);
        chk("rst target",     cp0_target_addr,     32'h0);
        idle();
        #5 rst = 1'b1;
        next_cycle();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d has_exp", i),    {31'b0, has_exp},    {31'b0, vecs[i].e_has});
            chk($sformatf("v%0d eret_taken", i), {31'b0, eret_taken}, {31'b0, vecs[i].e_eret});
            chk($sformatf("v%0d rdata", i),      rdata,               vecs[i].e_rd);
            chk($sformatf("v%0d target", i),     cp0_target_addr,     vecs[i].e_tgt);
            next_cycle();
        end

        // Interrupt latency: enable IE/IM0, raise irq[0] just after edge N.
        idle(); is_mtc0 = 1'b1; cp0_addr = 5'd12; wdata = 32'h0000_0401;
        next_cycle();
        idle();
        irq[0] = 1'b1;
        #1 chk("irq after N", {31'b0, has_exp}, 32'h0);
        next_cycle();
        chk("irq after N+1", {31'b0, has_exp}, 32'h0);
        next_cycle();
        pc = 32'h300; is_mfc0 = 1'b1; cp0_addr = 5'd13;
        #1;
        chk("irq after N+2", {31'b0, has_exp}, 32'h1);
        chk("irq cause old", rdata, 32'h0000_0420);
        next_cycle();
        chk("irq held exl", {31'b0, has_exp}, 32'h0);
        chk("irq cause code", rdata, 32'h0000_0400);
        cp0_addr = 5'd14;
        #1 chk("irq epc", rdata, 32'h300);
        next_cycle();
        chk("irq held exl 2", {31'b0, has_exp}, 32'h0);

        // MTC0 setting IE while an interrupt is pending fires on the next cycle.
        idle(); is_mtc0 = 1'b1; cp0_addr = 5'd12; wdata = 32'h0000_0402;
        next_cycle();
        idle(); is_eret = 1'b1;
        #1 chk("ie0 eret taken", {31'b0, eret_taken}, 32'h1);
        next_cycle();
        idle();
        #1 chk("ie0 no exp", {31'b0, has_exp}, 32'h0);
        next_cycle();
        idle(); is_mtc0 = 1'b1; cp0_addr = 5'd12; wdata = 32'h0000_0401;
        #1 chk("ie set same cycle", {31'b0, has_exp}, 32'h0);
        next_cycle();
        idle(); pc = 32'h80;
        #1 chk("ie set next cycle", {31'b0, has_exp}, 32'h1);
        next_cycle();

        // Asynchronous reset mid-cycle while EXL=1 and EPC=0x80.
        idle(); pc = 32'h84; exc_syscall = 1'b1; is_mfc0 = 1'b1; cp0_addr = 5'd14;
        #1;
        chk("pre-rst has_exp", {31'b0, has_exp}, 32'h1);
        chk("pre-rst epc",     rdata,            32'h80);
        chk("pre-rst target",  cp0_target_addr,  32'h80);
        #1 rst = 1'b0;
        #1;
        chk("async rst has_exp", {31'b0, has_exp}, 32'h0);
        chk("async rst target",  cp0_target_addr,  32'h0);
        chk("async rst rdata",   rdata,            32'h0);
        irq = '0;
        idle(); is_mfc0 = 1'b1; cp0_addr = 5'd12;
        next_cycle();
        #2 rst = 1'b1;
        #1;
        chk("post-rst status", rdata, 32'h0);
        cp0_addr = 5'd13;
        #1 chk("post-rst cause", rdata, 32'h0);
        chk("post-rst has_exp", {31'b0, has_exp}, 32'h0);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
